// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin writeback arbiter for the register file write port, with busy scoreboard
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 req_valid,
    input  logic [3*ADDR_W-1:0]        req_addr,
    input  logic [3*DATA_W-1:0]        req_data,
    output logic [2:0]                 req_ready,
    input  logic                       sb_set_valid,
    input  logic [ADDR_W-1:0]          sb_set_addr,
    output logic                       reg_write_en,
    output logic [ADDR_W-1:0]          write_reg_addr,
    output logic [DATA_W-1:0]          write_data,
    output logic [(1<<ADDR_W)-1:0]     busy,
    output logic                       sb_err
);

    localparam int NREG = 1 << ADDR_W;

    logic [1:0]        rr_ptr;
    logic [1:0]        idx;
    logic [1:0]        win_idx;
    logic              xfer;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              addr_nz;
    logic              set_hit;
    logic              err_hit;
    logic [NREG-1:0]   busy_next;

    // Walk the three requesters starting at rr_ptr; first valid one wins.
    always_comb begin
        req_ready = '0;
        win_idx   = 2'd0;
        xfer      = 1'b0;
        idx       = rr_ptr;
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                if (!xfer && req_valid[idx]) begin
                    req_ready[idx] = 1'b1;
                    win_idx        = idx;
                    xfer           = 1'b1;
                end
                idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end
        end
    end

    assign win_addr = req_addr[win_idx*ADDR_W +: ADDR_W];
    assign win_data = req_data[win_idx*DATA_W +: DATA_W];
    assign addr_nz  = (win_addr != '0);
    assign set_hit  = sb_set_valid && (sb_set_addr != '0);

    // A same-cycle claim of the destination means a younger writer owns it.
    assign err_hit  = xfer && addr_nz && !busy[win_addr]
                      && !(set_hit && (sb_set_addr == win_addr));

    always_comb begin
        busy_next = busy;
        if (xfer && addr_nz) begin
            busy_next[win_addr] = 1'b0;
        end
        if (set_hit) begin
            busy_next[sb_set_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr         <= 2'd0;
            reg_write_en   <= 1'b0;
            write_reg_addr <= '0;
            write_data     <= '0;
            busy           <= '0;
            sb_err         <= 1'b0;
        end else begin
            if (xfer) begin
                rr_ptr         <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
                write_reg_addr <= win_addr;
                write_data     <= win_data;
            end
            reg_write_en <= xfer && addr_nz;
            busy         <= busy_next;
            if (err_hit) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - table-driven directed bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      req_valid;
    logic [3*AW-1:0] req_addr;
    logic [3*DW-1:0] req_data;
    logic [2:0]      req_ready;
    logic            sb_set_valid;
    logic [AW-1:0]   sb_set_addr;
    logic            reg_write_en;
    logic [AW-1:0]   write_reg_addr;
    logic [DW-1:0]   write_data;
    logic [31:0]     busy;
    logic            sb_err;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .sb_set_valid(sb_set_valid),
        .sb_set_addr(sb_set_addr), .reg_write_en(reg_write_en),
        .write_reg_addr(write_reg_addr), .write_data(write_data),
        .busy(busy), .sb_err(sb_err)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  v;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic        sv;
        logic [4:0]  sa;
        logic [2:0]  exp_ready;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [31:0] exp_busy;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rst, input logic [2:0] v,
                                input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic sv, input logic [4:0] sa,
                                input logic [2:0] er, input logic ew, input logic [4:0] ea,
                                input logic [31:0] ed, input logic [31:0] eb, input logic ee);
        vec_t t;
        t.rst = rst; t.v = v; t.a0 = a0; t.a1 = a1; t.a2 = a2;
        t.d0 = d0; t.d1 = d1; t.d2 = d2; t.sv = sv; t.sa = sa;
        t.exp_ready = er; t.exp_we = ew; t.exp_addr = ea;
        t.exp_data = ed; t.exp_busy = eb; t.exp_err = ee;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int i);
        reset        = t.rst;
        req_valid    = t.v;
        req_addr     = {t.a2, t.a1, t.a0};
        req_data     = {t.d2, t.d1, t.d0};
        sb_set_valid = t.sv;
        sb_set_addr  = t.sa;
        #1;
        chk($sformatf("v%0d req_ready", i), {29'd0, req_ready}, {29'd0, t.exp_ready});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d reg_write_en", i), {31'd0, reg_write_en}, {31'd0, t.exp_we});
        chk($sformatf("v%0d write_reg_addr", i), {27'd0, write_reg_addr}, {27'd0, t.exp_addr});
        chk($sformatf("v%0d write_data", i), write_data, t.exp_data);
        chk($sformatf("v%0d busy", i), busy, t.exp_busy);
        chk($sformatf("v%0d sb_err", i), {31'd0, sb_err}, {31'd0, t.exp_err});
        n_vec++;
    endtask

    initial begin
        //           rst v  a0 a1 a2 d0        d1           d2        sv sa  ready we addr data         busy   err
        tbl.push_back(mk(0, 7, 0, 0, 0, 'h11,     'h22,        'h33,     0, 0,  0, 0, 0, 0,           0,     0));
        tbl.push_back(mk(0, 7, 0, 0, 0, 'h11,     'h22,        'h33,     0, 0,  0, 0, 0, 0,           0,     0));
        tbl.push_back(mk(1, 7, 0, 0, 0, 'h11,     'h22,        'h33,     0, 0,  1, 0, 0, 'h11,        0,     0));
        tbl.push_back(mk(1, 6, 0, 0, 0, 'h11,     'h22,        'h33,     0, 0,  2, 0, 0, 'h22,        0,     0));
        tbl.push_back(mk(1, 4, 0, 0, 0, 'h11,     'h22,        'h33,     0, 0,  4, 0, 0, 'h33,        0,     0));
        // single write to a claimed x5
        tbl.push_back(mk(1, 0, 0, 0, 0, 'h11,     'h22,        'h33,     1, 5,  0, 0, 0, 'h33,        'h20,  0));
        tbl.push_back(mk(1, 1, 5, 0, 0, 'hA,      'h22,        'h33,     0, 0,  1, 1, 5, 'hA,         0,     0));
        // realign rr_ptr to 0 while claiming x1..x3
        tbl.push_back(mk(1, 4, 5, 0, 0, 'hA,      'h22,        'h77,     1, 1,  4, 0, 0, 'h77,        'h2,   0));
        tbl.push_back(mk(1, 0, 5, 0, 0, 'hA,      'h22,        'h77,     1, 2,  0, 0, 0, 'h77,        'h6,   0));
        tbl.push_back(mk(1, 0, 5, 0, 0, 'hA,      'h22,        'h77,     1, 3,  0, 0, 0, 'h77,        'hE,   0));
        // round-robin with all three valid, re-claiming each register before its next write
        tbl.push_back(mk(1, 7, 1, 2, 3, 'h101,    'h202,       'h303,    0, 0,  1, 1, 1, 'h101,       'hC,   0));
        tbl.push_back(mk(1, 7, 1, 2, 3, 'h101,    'h202,       'h303,    1, 1,  2, 1, 2, 'h202,       'hA,   0));
        tbl.push_back(mk(1, 7, 1, 2, 3, 'h101,    'h202,       'h303,    1, 2,  4, 1, 3, 'h303,       'h6,   0));
        tbl.push_back(mk(1, 7, 1, 2, 3, 'h111,    'h202,       'h303,    1, 3,  1, 1, 1, 'h111,       'hC,   0));
        tbl.push_back(mk(1, 7, 1, 2, 3, 'h111,    'h222,       'h303,    0, 0,  2, 1, 2, 'h222,       'h8,   0));
        tbl.push_back(mk(1, 7, 1, 2, 3, 'h111,    'h222,       'h333,    0, 0,  4, 1, 3, 'h333,       0,     0));
        // x0 write from the load unit
        tbl.push_back(mk(1, 2, 1, 0, 3, 'h111,    'hFFFF_FFFF, 'h333,    0, 0,  2, 0, 0, 'hFFFF_FFFF, 0,     0));
        // set/clear collision on x7
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,        0,           0,        1, 7,  0, 0, 0, 'hFFFF_FFFF, 'h80,  0));
        tbl.push_back(mk(1, 4, 0, 0, 7, 0,        0,           'h7777,   1, 7,  4, 1, 7, 'h7777,      'h80,  0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,        0,           0,        0, 0,  0, 0, 7, 'h7777,      'h80,  0));
        // unclaimed write to x9 raises sticky sb_err; sets to x0 are ignored
        tbl.push_back(mk(1, 1, 9, 0, 0, 'h99,     0,           0,        0, 0,  1, 1, 9, 'h99,        'h80,  1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,        0,           0,        0, 0,  0, 0, 9, 'h99,        'h80,  1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,        0,           0,        1, 0,  0, 0, 9, 'h99,        'h80,  1));
        // transfer, then reset on the following edge
        tbl.push_back(mk(1, 2, 0, 4, 0, 0,        'h44,        0,        0, 0,  2, 1, 4, 'h44,        'h80,  1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,        0,           0,        0, 0,  0, 0, 0, 0,           0,     0));
        // request held across reset is served afterwards
        tbl.push_back(mk(0, 4, 0, 0, 0, 0,        0,           'h55,     0, 0,  0, 0, 0, 0,           0,     0));
        tbl.push_back(mk(1, 4, 0, 0, 0, 0,        0,           'h55,     0, 0,  4, 0, 0, 'h55,        0,     0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Fairness: all three continuously valid on x0, rr_ptr starts at 0
        for (int k = 0; k < 6; k++) begin
            logic [2:0] exp_g;
            exp_g        = 3'b001 << (k % 3);
            reset        = 1'b1;
            req_valid    = 3'b111;
            req_addr     = '0;
            req_data     = {32'hA2, 32'hA1, 32'hA0};
            sb_set_valid = 1'b0;
            sb_set_addr  = '0;
            #1;
            chk($sformatf("rr%0d onehot", k), {31'd0, $onehot(req_ready)}, 32'd1);
            chk($sformatf("rr%0d req_ready", k), {29'd0, req_ready}, {29'd0, exp_g});
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d write_data", k), write_data, 32'hA0 + (k % 3));
            chk($sformatf("rr%0d reg_write_en", k), {31'd0, reg_write_en}, 32'd0);
            n_vec++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port among three writeback sources: ALU (requester 0), load unit (requester 1) and CSR unit (requester 2). Grants one request per cycle by round-robin, registers the winning write onto the register file's `reg_write_en` / `write_reg_addr` / `write_data` inputs, and keeps a 32-entry busy scoreboard so the decode stage can detect read-after-write hazards on pending destinations. It sits between the execute/memory stages and the register file.

## Interface
- `DATA_W`, default 32, width of write data.
- `ADDR_W`, default 5, register address width; the register count is 2^ADDR_W.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req_valid`  in  3  per-requester write request (bit i is requester i).
- `req_addr`  in  3×ADDR_W  destination registers, packed; requester i uses bits [i*ADDR_W +: ADDR_W].
- `req_data`  in  3×DATA_W  write data, packed the same way.
- `req_ready`  out  3  grant; a transfer occurs on a cycle where `req_valid[i] && req_ready[i]`.
- `sb_set_valid`  in  1  decode claims a destination register.
- `sb_set_addr`  in  ADDR_W  register being claimed.
- `reg_write_en`  out  1  write enable to the register file (registered).
- `write_reg_addr`  out  ADDR_W  write address (registered).
- `write_data`  out  DATA_W  write data (registered).
- `busy`  out  2^ADDR_W  scoreboard; bit r set means a write to register r is pending.
- `sb_err`  out  1  sticky flag: a write transferred to a nonzero register whose busy bit was clear.

## Operation
- **Arbitration**
  - Combinational and round-robin.
  - `rr_ptr` (0..2) names the highest-priority requester. Search order is `rr_ptr`, then `rr_ptr`+1, then `rr_ptr`+2, all mod 3.
  - Exactly one `req_ready` bit is high, for the first valid requester in that order. All bits are 0 when nothing is valid or when `reset` is low.
  - On a transfer from requester g, `rr_ptr` becomes (g+1) mod 3. With no transfer, `rr_ptr` holds.
- **Requester obligations**
  - Once `req_valid[i]` is asserted, the requester holds it, together with its addr and data, stable until the transfer.
  - `req_ready` does not depend on the requester's addr or data.
- **Output register**
  - On a transfer, the next edge loads `write_reg_addr` and `write_data` from the winner and sets `reg_write_en` = (addr != 0).
  - With no transfer, `reg_write_en` = 0 and addr/data hold their last values.
  - A write to x0 is accepted (the requester is unblocked) but never reaches the register file.
- **Scoreboard**
  - Set: `sb_set_valid` with addr r ≠ 0 sets `busy[r]` at the next edge.
  - Clear: a transfer with addr r ≠ 0 clears `busy[r]` at the next edge, in the same cycle as the transfer (not when `reg_write_en` rises).
  - Set and clear of the same r in one cycle: set wins, so `busy[r]` = 1. A younger instruction is claiming the register.
  - `busy[0]` is always 0. Sets to x0 are ignored.
  - Setting a register that is already busy leaves it busy (no counting). Only one write may be outstanding per register; decode enforces this.
- **sb_err**
  - Set when a transfer targets r ≠ 0 while `busy[r]` = 0 and no same-cycle set of r occurs.
  - Cleared only by reset.
- **Reset** (`reset` low at an edge)
  - `reg_write_en` = 0, `write_reg_addr` = 0, `write_data` = 0, `busy` = all 0, `rr_ptr` = 0, `sb_err` = 0.
  - `req_ready` = 0 while `reset` is low. Requests pending during reset stay pending and are served after reset deasserts.
  - A write captured in the output register one cycle before reset is dropped.

## Timing
- The register file writes on the edge after `reg_write_en` is high.
- Request to register-file write:
  - Transfer in cycle N.
  - `reg_write_en` high during cycle N+1.
  - Register file updated at the end of cycle N+1.
- Busy clear is visible in cycle N+1. Decode must forward or stall for one extra cycle; the arbiter provides no bypass.
- Throughput is one write per cycle. A persistently valid requester is granted at least once every 3 cycles.
- `req_ready` is combinational from `req_valid`, `rr_ptr` and `reset`. No other output is combinational.

## Test plan
- **Reset values:** hold `reset` low for 2 cycles with all requesters valid → `req_ready` = 000 throughout. After release, the first grant goes to requester 0. All outputs are 0 during reset.
- **Single write:** claim x5, then the ALU requests x5 with data 0x0000_000A → `req_ready[0]` in cycle N. In N+1: `reg_write_en` = 1, `write_reg_addr` = 5, `write_data` = 0xA. `busy[5]` = 0 from N+1. `sb_err` stays 0.
- **Round-robin:** all three valid continuously, with addrs 1, 2 and 3 all claimed → grant sequence 0,1,2,0,1,2. Each `req_ready` is one-hot. Outputs show addrs 1,2,3,1,2,3 on consecutive cycles.
- **x0 write:** the load unit requests x0 with data 0xFFFF_FFFF → `req_ready[1]` = 1. Next cycle `reg_write_en` = 0. `busy` is unchanged and `sb_err` = 0.
- **Set/clear collision:** `busy[7]` = 1. In one cycle, the CSR unit writes x7 and decode sets x7 → next cycle `busy[7]` = 1, `reg_write_en` = 1 with addr 7, and `sb_err` = 0.
- **Unclaimed write and mid-operation reset:** write x9 with `busy[9]` = 0 → `sb_err` = 1 and stays set. Then transfer a write and assert reset on the next edge → `reg_write_en` = 0 and `sb_err` = 0 after that edge.
